// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU load/store
// path (port 0) and the UART loader/debug path (port 1).
// Accesses are serialised through IDLE -> ISSUE -> (WAIT) -> RESP, and read
// data returns through a registered response pulse.
// Optional feature macro: DMEM_ARB_RR_EN
//   undefined: fixed priority to port 0 with a starvation guard for port 1
//   defined:   round-robin arbitration, no starvation counter
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_re,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic              p0_rsp_valid,
  input  logic              p1_re,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Value loaded into the latency counter when a read is issued.
  localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

  state_t            state;
  state_t            state_next;
  logic [2:0]        lat_cnt;
  logic              grant_q;
  logic              write_q;
  logic              rsp_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              req0;
  logic              req1;
  logic              any_req;
  logic              win1;
  logic              arb_now;

  assign req0    = p0_re | p0_we;
  assign req1    = p1_re | p1_we;
  assign any_req = req0 | req1;
  assign arb_now = (state == IDLE) && any_req;

`ifdef DMEM_ARB_RR_EN
  // Last port served; 0 after reset means port 0 counts as last served.
  logic last_grant;

  // Round-robin pick: on a tie the port not served last goes ahead.
  always_comb begin
    win1 = 1'b0;
    if (req0 && req1) begin
      win1 = ~last_grant;
    end else if (req1) begin
      win1 = 1'b1;
    end
  end

  // Remember which port was granted at each IDLE arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b0;
    end else if (arb_now) begin
      last_grant <= win1;
    end
  end
`else
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;

  // Fixed priority to port 0 unless port 1 has lost STARVE_LIMIT times in a row.
  always_comb begin
    win1 = 1'b0;
    if (req0 && req1) begin
      win1 = (starve_cnt == STARVE_MAX);
    end else if (req1) begin
      win1 = 1'b1;
    end
  end

  // Count port 1 losses (saturating), clear when port 1 finally wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 8'd0;
    end else if (arb_now && req1) begin
      if (win1) begin
        starve_cnt <= 8'd0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: writes return to IDLE straight after ISSUE, reads
  // wait out the memory latency before the response cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (write_q) begin
          state_next = IDLE;
        end else if (READ_LATENCY == 1) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt <= 3'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latch the winner's request in IDLE, run the latency counter,
  // and capture read data in RESP so the response pulse comes from a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q     <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      lat_cnt     <= 3'd0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_q <= win1;
            write_q <= win1 ? p1_we : p0_we;
            addr_q  <= win1 ? p1_addr : p0_addr;
            wdata_q <= win1 ? p1_wdata : p0_wdata;
          end
        end
        ISSUE: begin
          lat_cnt <= LAT_LOAD;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
        end
        RESP: begin
          rdata_q     <= mem_rdata;
          rsp_valid_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // The response pulse appears in the IDLE cycle after RESP; grant_q still
  // names the reading port then, since it only reloads at the end of IDLE.
  assign p0_ready     = (state == ISSUE) && !grant_q;
  assign p1_ready     = (state == ISSUE) &&  grant_q;
  assign mem_re       = (state == ISSUE) && !write_q;
  assign mem_we       = (state == ISSUE) &&  write_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign rsp_rdata    = rdata_q;
  assign p0_rsp_valid = rsp_valid_q && !grant_q;
  assign p1_rsp_valid = rsp_valid_q &&  grant_q;
  assign busy         = (state != IDLE);

endmodule
